debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: a bank of independent button/switch debouncers.
// Each channel optionally inverts its raw input, synchronizes it, accepts a new
// level only after it has persisted for STABLE_CYCLES clocks, and reports
// registered rise/fall pulses plus a one-shot long-press pulse.
module debounce_bank #(
    parameter int                  CHANNELS      = 3,
    parameter int                  STABLE_CYCLES = 2000000,
    parameter int                  LONG_CYCLES   = 100000000,
    parameter logic [CHANNELS-1:0] INVERT_MASK   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] key_raw,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_rise,
    output logic [CHANNELS-1:0] key_fall,
    output logic [CHANNELS-1:0] key_long,
    output logic                any_level
);

    // The stability counter only ever holds 0..STABLE_CYCLES-1.
    localparam int STABLE_W = $clog2(STABLE_CYCLES);
    // The hold counter saturates at LONG_CYCLES, so it must represent that value.
    localparam int HOLD_W   = $clog2(LONG_CYCLES + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(LONG_CYCLES);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel

        logic                sync_meta;
        logic                sync_out;
        logic [STABLE_W-1:0] stable_cnt;
        logic                level_q;
        logic                level_prev;
        logic                rise_q;
        logic                fall_q;
        logic [HOLD_W-1:0]   hold_cnt;
        logic                long_q;

        // Two-flop synchronizer; the polarity fix-up happens before the first flop
        // so everything downstream sees an active-high key.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_meta <= 1'b0;
                sync_out  <= 1'b0;
            end else begin
                sync_meta <= key_raw[ch] ^ INVERT_MASK[ch];
                sync_out  <= sync_meta;
            end
        end

        // Count consecutive disagreeing cycles; flip the accepted level on the last one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable_cnt <= '0;
                level_q    <= 1'b0;
            end else if (sync_out == level_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt == STABLE_LAST) begin
                stable_cnt <= '0;
                level_q    <= ~level_q;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end

        // Registered edge pulses, one cycle after the accepted level changes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_prev <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
            end else begin
                level_prev <= level_q;
                rise_q     <= level_q & ~level_prev;
                fall_q     <= ~level_q & level_prev;
            end
        end

        // Saturating press-duration counter; the pulse fires on the single cycle it reaches the limit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= level_q && (hold_cnt == HOLD_LAST);
                if (!level_q) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end

        assign key_level[ch] = level_q;
        assign key_rise[ch]  = rise_q;
        assign key_fall[ch]  = fall_q;
        assign key_long[ch]  = long_q;

    end

    assign any_level = |key_level;

endmodule
